countdown_ctrl: RTL
===================

# countdown_ctrl

Sequencing controller that sits directly upstream of the 4-bit synchronous down counter and drives its `ld` and `en` inputs. It accepts a start request on a valid/ready handshake and loads the counter to all-ones. It then paces decrements through a prescaler and watches the counter value for zero. On reaching zero it issues a one-cycle `done` pulse, and in repeat mode it reloads automatically; an `abort` input cancels a run at any point.

## Interface
Parameters:
- `CW`, 4, width of the counter value fed back from the down counter.
- `PRESCALE`, 4, system cycles per decrement; legal range 1..256.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start_valid` input 1: start request.
- `start_ready` output 1: controller can accept a start.
- `repeat_mode` input 1: sampled on start handshake; 1 = auto-reload after each done.
- `abort` input 1: cancel the current run.
- `cnt_q` input CW: current value of the down counter.
- `cnt_ld` output 1: drives counter `ld`; load all-ones.
- `cnt_en` output 1: drives counter `en`; decrement by 1.
- `busy` output 1: high in LOAD, RUN and DONE.
- `done` output 1: one-cycle pulse when a countdown completes.
- `aborted` output 1: one-cycle pulse when a run is cancelled.
- `pass_cnt` output 8: completed countdowns since the last accepted start; wraps 255->0.

## Operation
- The state machine has four states: IDLE, LOAD, RUN, DONE. Reset forces IDLE.
- The controller never drives the counter's `rst`; `cnt_ld` alone establishes the start value.
- Output decode:
  - `start_ready` = (IDLE) & ~`abort`.
  - `cnt_ld` = 1 only in LOAD.
  - `done` = 1 only in DONE.
  - `busy` = state != IDLE.
  - `cnt_en` and `cnt_ld` are never high in the same cycle.
- IDLE:
  - On `start_valid` & `start_ready`: latch `repeat_mode` into `rep_r`, clear `pass_cnt` to 0, go to LOAD.
  - `abort` in IDLE has no effect except blocking `start_ready`.
- LOAD: lasts exactly one cycle with `cnt_ld`=1. Clear the prescaler to 0 and go to RUN.
- RUN, prescaler behaviour:
  - The prescaler counts 0..PRESCALE-1 and wraps.
  - At terminal value PRESCALE-1 with `cnt_q` != 0: `cnt_en`=1 for that single cycle.
  - At terminal value PRESCALE-1 with `cnt_q` == 0: no `cnt_en`; go to DONE. The counter is never decremented below 0, so it never wraps to all-ones.
  - When PRESCALE=1 the prescaler is always terminal.
- DONE: lasts one cycle. Increment `pass_cnt`.
  - If `rep_r`=1 and `abort`=0: go to LOAD.
  - Otherwise: go to IDLE.
- Abort:
  - `abort`=1 in LOAD or RUN: go to IDLE next edge, `aborted` pulses 1 cycle, no `done`, `pass_cnt` unchanged.
  - In the abort cycle itself, `cnt_en` and `cnt_ld` are forced to 0.
  - `abort` in DONE: `done` still pulses, `pass_cnt` still increments, then IDLE (suppresses repeat); `aborted` does not pulse.
- Reset mid-operation: immediate return to IDLE. All outputs go low, `pass_cnt`=0, prescaler=0, `rep_r`=0.

## Timing
- Reset values while `rst`=1:
  - `start_ready`=0, `cnt_ld`=0, `cnt_en`=0, `busy`=0, `done`=0, `aborted`=0, `pass_cnt`=0.
  - `start_ready` rises in the first cycle after `rst` deasserts.
- Handshake accepted in cycle T:
  - LOAD in T+1.
  - RUN spans T+2 .. T+1+2^CW·PRESCALE.
  - DONE in T+2+2^CW·PRESCALE.
  - Defaults: RUN is 64 cycles and DONE is at T+66.
- `cnt_q` is 2^CW-1 from the first RUN cycle, because the counter loads on the edge ending LOAD.
- Exactly 2^CW-1 `cnt_en` pulses occur per pass, spaced exactly PRESCALE cycles apart. The first is at RUN cycle PRESCALE-1.
- Repeat period is 2^CW·PRESCALE+2 cycles from LOAD to LOAD.
- All state and outputs are registered or decoded from registered state. The only combinational input-to-output paths are `abort` into `start_ready`/`cnt_en`/`cnt_ld` and `cnt_q` into `cnt_en`.

## Test plan
- Reset: assert `rst` mid-RUN -> all outputs 0 immediately; after release, `start_ready`=1 and no `cnt_en` appears.
- Single pass, defaults, with the real down counter attached: start at T -> `cnt_ld` at T+1; 15 `cnt_en` pulses 4 cycles apart; `cnt_q` reaches 0; `done` at T+66; `pass_cnt`=1; IDLE at T+67.
- Repeat mode, 3 passes: `done` at T+66, T+132 and T+198 -> `pass_cnt`=3; `cnt_q` never wraps from 0 to 15 except via `cnt_ld`.
- Abort at RUN cycle 20 -> `aborted` pulse, no `done`, `cnt_en`=0 that cycle, `busy` low next cycle, `pass_cnt` unchanged.
- Abort coincident with DONE in repeat mode -> `done`=1, `pass_cnt` increments, no LOAD follows, `aborted`=0.
- PRESCALE=1: start -> `cnt_en` high for 15 consecutive RUN cycles; `done` at T+18; `start_valid` held high in IDLE with `abort`=1 -> not accepted.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Sequencing controller for a 4-bit down counter: start handshake, paced
// decrements through a prescaler, done/abort pulses and optional auto-reload.
module countdown_ctrl #(
    parameter int CW       = 4,
    parameter int PRESCALE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic          repeat_mode,
    input  logic          abort,
    input  logic [CW-1:0] cnt_q,
    output logic          cnt_ld,
    output logic          cnt_en,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [7:0]    pass_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state;
    logic       rep_r;
    logic [7:0] presc;
    logic       live;
    logic       presc_term;

    // live holds start_ready low until the first edge after reset releases
    assign presc_term  = (presc == 8'(PRESCALE - 1));
    assign start_ready = (state == IDLE) & live & ~abort;
    assign cnt_ld      = (state == LOAD) & ~abort;
    assign cnt_en      = (state == RUN) & presc_term & (cnt_q != '0) & ~abort;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rep_r    <= 1'b0;
            presc    <= '0;
            live     <= 1'b0;
            aborted  <= 1'b0;
            pass_cnt <= '0;
        end else begin
            live    <= 1'b1;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        rep_r    <= repeat_mode;
                        pass_cnt <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        presc <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else if (presc_term) begin
                        // a zero counter at the terminal tick ends the pass instead of wrapping
                        presc <= '0;
                        if (cnt_q == '0)
                            state <= DONE;
                    end else begin
                        presc <= presc + 8'd1;
                    end
                end
                DONE: begin
                    pass_cnt <= pass_cnt + 8'd1;
                    if (rep_r && !abort)
                        state <= LOAD;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
